// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_ADDR_W     = 30;
  localparam int DEFAULT_STARVE_MAX = 4;

  // Return tracker: names the owner of the read data arriving this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2
  } ret_state_e;

  // Which requester launched a memory read in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // A byte address is legal only if every bit above the word-address field is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory port of the arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEFAULT_ADDR_W
);
  // fetch port
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  // data port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wbyte;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              addr_err;
  // memory port
  logic              mem_read_ready;
  logic              mem_write_ready;
  logic [ADDR_W-1:0] mem_read_address;
  logic [ADDR_W-1:0] mem_write_address;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_byte;
  logic [31:0]       mem_read_data;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wbyte, mem_read_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err,
           mem_read_ready, mem_write_ready, mem_read_address, mem_write_address,
           mem_write_data, mem_write_byte
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wbyte, mem_read_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, addr_err,
           mem_read_ready, mem_write_ready, mem_read_address, mem_write_address,
           mem_write_data, mem_write_byte
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles the fetch port has been denied.
module starve_counter #(
  parameter int MAX = mem_arb_pkg::DEFAULT_STARVE_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; hold once the ceiling is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == W'(MAX));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data
// load/store. Data wins unless fetch has starved for MAX cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  logic       sat;
  logic       i_gnt, d_gnt;
  logic       i_ok, d_ok;
  owner_e     gnt_owner;

  ret_state_e state_q, state_d;
  logic       i_rvalid_q, i_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;
  logic       addr_err_q, addr_err_d;
  logic       rd_zero_q, rd_zero_d;

  // Grants are gated by reset so nothing is issued while it is held low.
  assign i_gnt = reset & bus.i_req & (~bus.d_req | sat);
  assign d_gnt = reset & bus.d_req & ~(bus.i_req & sat);

  assign i_ok = addr_in_range(bus.i_addr, ADDR_W);
  assign d_ok = addr_in_range(bus.d_addr, ADDR_W);

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.i_req & ~i_gnt),
    .clr   (i_gnt | ~bus.i_req),
    .sat   (sat)
  );

  // Owner of any read granted this cycle (a store owns no return slot).
  always_comb begin
    gnt_owner = OWN_NONE;
    if (i_gnt) begin
      gnt_owner = OWN_I;
    end else if (d_gnt && !bus.d_we) begin
      gnt_owner = OWN_D;
    end
  end

  // Memory strobes: an out-of-range request is consumed without touching memory.
  assign bus.i_gnt             = i_gnt;
  assign bus.d_gnt             = d_gnt;
  assign bus.mem_read_ready    = (i_gnt & i_ok) | (d_gnt & ~bus.d_we & d_ok);
  assign bus.mem_write_ready   = d_gnt & bus.d_we & d_ok;
  assign bus.mem_read_address  = i_gnt ? bus.i_addr[ADDR_W+1:2] : bus.d_addr[ADDR_W+1:2];
  assign bus.mem_write_address = bus.d_addr[ADDR_W+1:2];
  assign bus.mem_write_data    = bus.d_wdata;
  assign bus.mem_write_byte    = bus.d_wbyte;

  // Next return-tracker state and registered status outputs.
  always_comb begin
    case (gnt_owner)
      OWN_I:   state_d = I_RD;
      OWN_D:   state_d = D_RD;
      default: state_d = IDLE;
    endcase
    i_rvalid_d = (state_d == I_RD);
    d_rvalid_d = (state_d == D_RD);
    addr_err_d = (i_gnt & ~i_ok) | (d_gnt & ~d_ok);
    rd_zero_d  = (i_gnt & ~i_ok) | (d_gnt & ~bus.d_we & ~d_ok);
  end

  // Return tracker FSM; reset discards any in-flight read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      addr_err_q <= 1'b0;
      rd_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      addr_err_q <= addr_err_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  // Route the returning word to its owner; a trapped read returns zero.
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.i_rdata  = (state_q == I_RD && !rd_zero_q) ? bus.mem_read_data : 32'd0;
  assign bus.d_rdata  = (state_q == D_RD && !rd_zero_q) ? bus.mem_read_data : 32'd0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data load/store port. Each cycle it grants one request, drives the memory's read or write strobes, and routes the returned read data back to the owning requester. Data accesses win by default, and an anti-starvation counter guarantees forward progress for fetch. Illegal addresses are trapped before they reach the memory.

## Interface
- `ADDR_W`, 30 — memory word-address width; byte address bits above `ADDR_W+1` must be zero.
- `STARVE_MAX`, 4 — consecutive denied fetch cycles before fetch is forced to win.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low.
- `i_req`  in  1  — fetch read request.
- `i_addr`  in  32  — fetch byte address.
- `i_gnt`  out  1  — fetch request accepted this cycle.
- `i_rvalid`  out  1  — fetch data valid.
- `i_rdata`  out  32  — fetch data.
- `d_req`  in  1  — data request.
- `d_we`  in  1  — 1 = store, 0 = load.
- `d_addr`  in  32  — data byte address.
- `d_wdata`  in  32  — store data.
- `d_wbyte`  in  4  — store byte enables.
- `d_gnt`  out  1  — data request accepted this cycle.
- `d_rvalid`  out  1  — load data valid.
- `d_rdata`  out  32  — load data.
- `addr_err`  out  1  — registered pulse: granted request had an out-of-range address.
- `mem_read_ready`, `mem_write_ready`  out  1 each  — memory strobes.
- `mem_read_address`, `mem_write_address`  out  `ADDR_W` each  — word addresses, taken as `addr[ADDR_W+1:2]`.
- `mem_write_data`  out  32; `mem_write_byte`  out  4.
- `mem_read_data`  in  32  — valid one cycle after `mem_read_ready`.

## Operation
- **Grant logic** (combinational, same cycle as the request):
  - Default: `d_req` wins.
  - If `starve_cnt == STARVE_MAX` and `i_req` is high, fetch wins.
  - At most one grant per cycle.
- **Starvation counter** `starve_cnt` (width `clog2(STARVE_MAX+1)`):
  - Increments when `i_req` is high and `i_gnt` is low.
  - Clears on `i_gnt` or when `i_req` is low.
  - Saturates at `STARVE_MAX`.
- **Issue:**
  - Granted load or fetch → `mem_read_ready=1`, read address driven.
  - Granted store → `mem_write_ready=1`, write address, data and byte enables driven. A store completes in its grant cycle and produces no `rvalid`.
- **Range check:** if `addr[31:ADDR_W+2] != 0`, the request is still granted (consumed) but no memory strobe is issued.
  - `addr_err` pulses the next cycle.
  - For a read, the requester's `rvalid` still pulses, with `rdata = 0`.
- **Return tracker FSM**, registered:
  - States: `IDLE`, `I_RD`, `D_RD`.
  - Next state is `I_RD` after a fetch grant, `D_RD` after a load grant, `IDLE` otherwise (no grant, or a store).
  - Back-to-back grants are allowed. Each cycle's state names the owner of the current `mem_read_data`.
- **Outputs by state:**
  - `I_RD`: `i_rvalid=1`, `i_rdata=mem_read_data`.
  - `D_RD`: `d_rvalid=1`, `d_rdata=mem_read_data`.
  - Non-owner `rdata` is held at 0.
- **Misalignment:** `addr[1:0]` is ignored, with no error.

## Timing
- Grant and memory strobes are combinational from the requests in the same cycle.
- Read latency: `rvalid` is asserted exactly 1 cycle after the grant.
- Throughput: one access per cycle.
- Simultaneous `i_req` and `d_req`:
  - Data is granted; fetch is held off.
  - Fetch is guaranteed a grant within `STARVE_MAX+1` cycles.
- A requester keeps `req` and its payload stable until granted.
- **Reset** (async assert, mid-operation included):
  - FSM → `IDLE`; `starve_cnt` = 0; `i_rvalid` = `d_rvalid` = `addr_err` = 0.
  - Any in-flight read is discarded.
  - Grants and strobes are forced to 0 while `reset` is low.
- Deassertion is synchronous to `clk`; the first grant is possible in the first cycle with `reset` high.

## Structure
- **Shared package `mem_arb_pkg`:**
  - FSM state enum (`IDLE`, `I_RD`, `D_RD`).
  - Owner encoding.
  - Default `ADDR_W` and `STARVE_MAX` constants.
- **One sub-module, `starve_counter`:** saturating counter with `inc` and `clr` inputs and a `sat` output.
- Grant mux, range check and return FSM live in the top module.

## Test plan
- **Fetch only:** `i_req=1`, `i_addr=0x10` for 3 cycles.
  - `i_gnt=1` each cycle, `mem_read_address=4`.
  - `i_rvalid` on cycles +1..+3 with memory word 4.
- **Load only:** `d_req`, `d_we=0`, `d_addr=0x20`.
  - `d_gnt` is immediate; `d_rvalid` next cycle with word 8.
  - `i_rvalid` stays 0.
- **Store:** `d_we=1`, `d_addr=0x8`, `d_wdata=0xDEADBEEF`, `d_wbyte=0xF`.
  - `mem_write_ready=1` with address 2 that cycle; no `d_rvalid`.
  - A later load of `0x8` returns `0xDEADBEEF`.
- **Contention:** `i_req` and `d_req` both held high, `STARVE_MAX=4`.
  - Grant pattern is D,D,D,D,I repeating; `rvalid` owners follow the same pattern one cycle later.
- **Out of range:** `d_addr=0x4000` with `ADDR_W=10`.
  - Granted, no memory strobe.
  - `addr_err` and `d_rvalid` pulse next cycle with `d_rdata=0`.
- **Reset mid-read:** assert `reset` low in the cycle after a load grant.
  - `d_rvalid` stays 0; state returns to `IDLE`; `starve_cnt=0`.
  - After release, a new fetch is granted immediately.
